// File: rtl/core_pkg.sv
// Shared encodings for the branch/hazard sequencer: branch-control codes,
// sequencer FSM states and PC source selects.
package core_pkg;

  typedef enum logic [1:0] {
    BC_JALR  = 2'd0,
    BC_TAKEN = 2'd1,
    BC_SEQ   = 2'd2,
    BC_RSVD  = 2'd3
  } b_ctrl_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REDIR_WAIT = 2'd1,
    ST_FREEZE     = 2'd2
  } seq_state_e;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

  function automatic logic is_redirect(input logic [1:0] b_ctrl);
    return (b_ctrl == BC_JALR) || (b_ctrl == BC_TAKEN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts single-cycle pulses and holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (inc && (out != {CNT_W{1'b1}})) begin
      out <= out + 1'b1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline sequencer: resolves EX redirects, load-use stalls and data-memory
// freezes into PC / pipeline-register controls, with perf counters.
module branch_hazard_ctrl
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [1:0]       ex_b_ctrl,
  input  logic [XLEN-1:0]  ex_pc_imm,
  input  logic [XLEN-1:0]  ex_alu_out,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  // Handshake: fetch takes pc_target/PC+4 only in a cycle where pc_we=1 and
  // imem_ready=1; otherwise the PC holds and the request is presented again.
  seq_state_e      state_q, ret_q, eff_state, next_state;
  logic [XLEN-1:0] tgt_q, tgt_comb;
  logic            redir_req, load_use;
  logic            capture_tgt, set_misalign, redir_inc, stall_inc;

  assign redir_req = ex_valid && is_redirect(ex_b_ctrl);
  assign load_use  = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
  assign tgt_comb  = ((ex_b_ctrl == BC_JALR) ? ex_alu_out : ex_pc_imm) & BIT0_MASK;

  // Leaving FREEZE behaves exactly like the state it interrupted.
  assign eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

  always_comb begin
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_SEQ;
    pc_target    = '0;
    ifid_we      = 1'b0;
    idex_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    capture_tgt  = 1'b0;
    set_misalign = 1'b0;
    redir_inc    = 1'b0;
    stall_inc    = 1'b0;
    next_state   = eff_state;

    if (dmem_busy) begin
      next_state = ST_FREEZE;
      if (eff_state == ST_REDIR_WAIT) begin
        pc_sel    = PC_SEL_TGT;
        pc_target = tgt_q;
      end
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (redir_req) begin
            pc_sel       = PC_SEL_TGT;
            pc_target    = tgt_comb;
            ifid_we      = 1'b1;
            idex_we      = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redir_inc    = 1'b1;
            set_misalign = tgt_comb[1];
            if (imem_ready) begin
              pc_we = 1'b1;
            end else begin
              capture_tgt = 1'b1;
              next_state  = ST_REDIR_WAIT;
            end
          end else if (load_use) begin
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else begin
            pc_we      = imem_ready;
            ifid_we    = 1'b1;
            idex_we    = 1'b1;
            ifid_flush = !imem_ready;
          end
        end
        ST_REDIR_WAIT: begin
          pc_sel     = PC_SEL_TGT;
          pc_target  = tgt_q;
          pc_we      = imem_ready;
          ifid_we    = 1'b1;
          idex_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (imem_ready) next_state = ST_RUN;
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      ret_q        <= ST_RUN;
      tgt_q        <= '0;
      misalign_err <= 1'b0;
    end else begin
      state_q <= next_state;
      if (dmem_busy) ret_q <= eff_state;
      if (capture_tgt) tgt_q <= tgt_comb;
      if (set_misalign) misalign_err <= 1'b1;
    end
  end

  assign state = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redir_inc),
    .out   (redirect_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .out   (stall_cnt)
  );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; counters built 4 bits wide so
// saturation is reachable in a handful of redirects.
module tb_branch_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, ex_mem_read, id_use_rs1, id_use_rs2;
  logic             imem_ready, dmem_busy;
  logic [1:0]       ex_b_ctrl;
  logic [XLEN-1:0]  ex_pc_imm, ex_alu_out;
  logic [4:0]       ex_rd, id_rs1, id_rs2;
  logic             pc_we, pc_sel, ifid_we, idex_we, ifid_flush, idex_flush;
  logic             misalign_err;
  logic [XLEN-1:0]  pc_target;
  logic [CNT_W-1:0] redirect_cnt, stall_cnt;
  logic [1:0]       state;

  int total = 0;
  int bad   = 0;

  branch_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_b_ctrl    (ex_b_ctrl),
    .ex_pc_imm    (ex_pc_imm),
    .ex_alu_out   (ex_alu_out),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .imem_ready   (imem_ready),
    .dmem_busy    (dmem_busy),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_b_ctrl = 2'd2; ex_pc_imm = '0; ex_alu_out = '0;
    ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; imem_ready = 1'b0; dmem_busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    settle();
    chk("rst_state", state, 2'd0);
    chk("rst_redir_cnt", redirect_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_target", pc_target, 0);

    // Enter REDIR_WAIT with a misaligned target, then reset asynchronously.
    ex_valid = 1'b1; ex_b_ctrl = 2'd1; ex_pc_imm = 32'h106;
    settle();
    chk("pre_pc_we", pc_we, 0);
    tick();
    ex_valid = 1'b0;
    settle();
    chk("pre_state_wait", state, 2'd1);
    chk("pre_redir_cnt", redirect_cnt, 1);
    chk("pre_misalign", misalign_err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 2'd0);
    chk("async_rst_pc_we", pc_we, 0);
    chk("async_rst_redir_cnt", redirect_cnt, 0);
    chk("async_rst_misalign", misalign_err, 0);
    tick();
    rst_n = 1'b1;

    // Taken branch with fetch ready: immediate redirect.
    imem_ready = 1'b1; ex_valid = 1'b1; ex_b_ctrl = 2'd1; ex_pc_imm = 32'h100;
    settle();
    chk("br_pc_sel", pc_sel, 1);
    chk("br_target", pc_target, 32'h100);
    chk("br_pc_we", pc_we, 1);
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    tick();
    ex_valid = 1'b0;
    settle();
    chk("br_redir_cnt", redirect_cnt, 1);
    chk("br_state", state, 2'd0);
    chk("br_misalign", misalign_err, 0);

    // JALR to 0x203 while fetch is stalled for three cycles.
    ex_valid = 1'b1; ex_b_ctrl = 2'd0; ex_alu_out = 32'h203; imem_ready = 1'b0;
    settle();
    chk("jalr_target", pc_target, 32'h202);
    chk("jalr_c1_pc_we", pc_we, 0);
    chk("jalr_c1_flush", {ifid_flush, idex_flush}, 2'b11);
    tick();
    ex_valid = 1'b1; ex_b_ctrl = 2'd1; ex_pc_imm = 32'h500;
    settle();
    chk("jalr_state_wait", state, 2'd1);
    chk("jalr_misalign", misalign_err, 1);
    chk("jalr_c2_pc_we", pc_we, 0);
    chk("jalr_c2_target_held", pc_target, 32'h202);
    chk("jalr_c2_flush", {ifid_flush, idex_flush}, 2'b11);
    tick();
    ex_valid = 1'b0;
    settle();
    chk("jalr_c3_pc_we", pc_we, 0);
    chk("jalr_c3_target", pc_target, 32'h202);
    chk("jalr_ignored_redir", redirect_cnt, 2);
    tick();
    imem_ready = 1'b1;
    settle();
    chk("jalr_c4_pc_we", pc_we, 1);
    chk("jalr_c4_pc_sel", pc_sel, 1);
    chk("jalr_c4_target", pc_target, 32'h202);
    tick();
    chk("jalr_back_run", state, 2'd0);
    chk("jalr_redir_cnt", redirect_cnt, 2);

    // Load-use on rs2 produces a single bubble.
    ex_valid = 1'b1; ex_b_ctrl = 2'd2; ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    settle();
    chk("lu_pc_we", pc_we, 0);
    chk("lu_ifid_we", ifid_we, 0);
    chk("lu_idex_flush", idex_flush, 1);
    tick();
    ex_valid = 1'b0;
    settle();
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_after_pc_we", pc_we, 1);
    chk("lu_after_ifid_we", ifid_we, 1);
    chk("lu_after_idex_flush", idex_flush, 0);

    // x0 destination never stalls.
    ex_valid = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    settle();
    chk("lu_x0_pc_we", pc_we, 1);
    chk("lu_x0_idex_flush", idex_flush, 0);
    tick();
    chk("lu_x0_stall_cnt", stall_cnt, 1);

    // Load-use together with a taken branch: redirect wins.
    ex_rd = 5'd5; id_rs2 = 5'd5; ex_b_ctrl = 2'd1; ex_pc_imm = 32'h300;
    settle();
    chk("prio_flush", {ifid_flush, idex_flush}, 2'b11);
    chk("prio_pc_sel", pc_sel, 1);
    chk("prio_pc_we", pc_we, 1);
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0; id_use_rs2 = 1'b0;
    settle();
    chk("prio_stall_cnt", stall_cnt, 1);
    chk("prio_redir_cnt", redirect_cnt, 3);

    // Freeze for two cycles while a redirect is pending.
    ex_valid = 1'b1; ex_b_ctrl = 2'd1; ex_pc_imm = 32'h400; imem_ready = 1'b0;
    tick();
    ex_valid = 1'b0; dmem_busy = 1'b1;
    settle();
    chk("frz_c1_state_wait", state, 2'd1);
    chk("frz_c1_enables", {pc_we, ifid_we, idex_we}, 3'b000);
    chk("frz_c1_flushes", {ifid_flush, idex_flush}, 2'b00);
    tick();
    imem_ready = 1'b1; ex_valid = 1'b1; ex_pc_imm = 32'h600;
    settle();
    chk("frz_c2_state", state, 2'd2);
    chk("frz_c2_enables", {pc_we, ifid_we, idex_we}, 3'b000);
    tick();
    dmem_busy = 1'b0; ex_valid = 1'b0; imem_ready = 1'b0;
    settle();
    chk("frz_c3_state", state, 2'd2);
    chk("frz_c3_pc_we", pc_we, 0);
    chk("frz_c3_target", pc_target, 32'h400);
    chk("frz_c3_flushes", {ifid_flush, idex_flush}, 2'b11);
    tick();
    chk("frz_back_wait", state, 2'd1);
    imem_ready = 1'b1;
    settle();
    chk("frz_release_pc_we", pc_we, 1);
    chk("frz_release_target", pc_target, 32'h400);
    tick();
    chk("frz_back_run", state, 2'd0);
    chk("frz_redir_cnt", redirect_cnt, 4);

    // Drive the 4-bit redirect counter past all-ones.
    ex_valid = 1'b1; ex_b_ctrl = 2'd1; ex_pc_imm = 32'h100;
    for (int i = 0; i < 11; i++) tick();
    chk("sat_reach_max", redirect_cnt, 4'hf);
    for (int i = 0; i < 3; i++) tick();
    ex_valid = 1'b0;
    settle();
    chk("sat_hold_max", redirect_cnt, 4'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
